// File: rtl/synch_fifo_param.sv
// synch_fifo_param: single-clock FIFO with arbitrary depth, programmable
// almost-full/almost-empty thresholds, live occupancy count, registered or
// first-word-fall-through read mode, and sticky overflow/underflow flags.
module synch_fifo_param #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 2,
    parameter bit FWFT   = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_en,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop_en,
    output logic [DATA_W-1:0]          pop_data,
    output logic                       pop_valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    // Parameter legality is checked while elaborating so a bad instance
    // never reaches simulation or synthesis silently.
    if (DATA_W < 1) begin : g_bad_data_w
        $error("synch_fifo_param: DATA_W (%0d) must be >= 1", DATA_W);
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("synch_fifo_param: DEPTH (%0d) must be >= 2", DEPTH);
    end
    if (AF_LVL < 1 || AF_LVL > DEPTH) begin : g_bad_af
        $error("synch_fifo_param: AF_LVL (%0d) must be in 1..DEPTH", AF_LVL);
    end
    if (AE_LVL < 0 || AE_LVL > DEPTH - 1) begin : g_bad_ae
        $error("synch_fifo_param: AE_LVL (%0d) must be in 0..DEPTH-1", AE_LVL);
    end

    // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Sticky error flag update: a violation on this edge wins over a clear.
    function automatic logic sticky_next(input logic cur, input logic hit, input logic clr);
        if (hit) begin
            return 1'b1;
        end
        if (clr) begin
            return 1'b0;
        end
        return cur;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              push_ok;
    logic              pop_ok;
    logic              overflow_q;
    logic              underflow_q;

    // Flags are pure decodes of the registered occupancy.
    always_comb begin
        full         = (count_q == CNT_W'(DEPTH));
        empty        = (count_q == '0);
        almost_full  = (count_q >= CNT_W'(AF_LVL));
        almost_empty = (count_q <= CNT_W'(AE_LVL));
        // Acceptance looks at this cycle's flags only; a simultaneous pop
        // does not make room for a push into a full FIFO (and vice versa).
        push_ok      = push_en && !full;
        pop_ok       = pop_en && !empty;
    end

    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // Storage array: written on accepted pushes, never reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Write/read pointers advance on their accepted operations.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    // Occupancy: a lone push adds one, a lone pop removes one.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (push_ok && !pop_ok) begin
            count_q <= count_q + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    // Sticky overflow/underflow, cleared by clr_err or reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= sticky_next(overflow_q, push_en && full, clr_err);
            underflow_q <= sticky_next(underflow_q, pop_en && empty, clr_err);
        end
    end

    if (FWFT) begin : g_fwft
        // Head of the queue is always visible; pop_en just retires it.
        always_comb begin
            pop_data  = mem[rd_ptr];
            pop_valid = !empty;
        end
    end else begin : g_reg_rd
        logic [DATA_W-1:0] rd_data_p1;
        logic              vld_p1;

        // ---- read stage: accepted pop captures the head, valid for one cycle
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_data_p1 <= '0;
                vld_p1     <= 1'b0;
            end else begin
                vld_p1 <= pop_ok;
                if (pop_ok) begin
                    rd_data_p1 <= mem[rd_ptr];
                end
            end
        end

        assign pop_data  = rd_data_p1;
        assign pop_valid = vld_p1;
    end

    // Occupancy must never exceed the storage size.
    a_count_range: assert property (@(posedge clk) disable iff (rst) count_q <= CNT_W'(DEPTH))
        else $error("synch_fifo_param: count out of range");

    // Pointers must always address a real entry.
    a_ptr_range: assert property (@(posedge clk) disable iff (rst)
                                  (wr_ptr <= PTR_W'(DEPTH - 1)) && (rd_ptr <= PTR_W'(DEPTH - 1)))
        else $error("synch_fifo_param: pointer out of range");

endmodule

// File: tb/tb_synch_fifo_param.sv
// Bench for synch_fifo_param: one registered-read instance (DEPTH 8) and one
// FWFT instance (DEPTH 6), driven by directed and random traffic and checked
// against a queue-based reference model with a decoupled data scoreboard.
module tb_synch_fifo_param;

    localparam int DA = 8;
    localparam int DB = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: registered read, DEPTH 8, AF 6, AE 2
    logic       push_en_a = 1'b0, pop_en_a = 1'b0, clr_err_a = 1'b0;
    logic [7:0] push_data_a = '0, pop_data_a;
    logic       pop_valid_a, full_a, empty_a, almost_full_a, almost_empty_a, overflow_a, underflow_a;
    logic [3:0] count_a;

    // Instance B: FWFT, DEPTH 6, AF default (4), AE 2
    logic       push_en_b = 1'b0, pop_en_b = 1'b0, clr_err_b = 1'b0;
    logic [7:0] push_data_b = '0, pop_data_b;
    logic       pop_valid_b, full_b, empty_b, almost_full_b, almost_empty_b, overflow_b, underflow_b;
    logic [2:0] count_b;

    synch_fifo_param #(.DATA_W(8), .DEPTH(DA), .AF_LVL(6), .AE_LVL(2), .FWFT(1'b0)) u_dut_a (
        .clk(clk), .rst(rst),
        .push_en(push_en_a), .push_data(push_data_a),
        .pop_en(pop_en_a), .pop_data(pop_data_a), .pop_valid(pop_valid_a),
        .count(count_a), .full(full_a), .empty(empty_a),
        .almost_full(almost_full_a), .almost_empty(almost_empty_a),
        .overflow(overflow_a), .underflow(underflow_a), .clr_err(clr_err_a)
    );

    synch_fifo_param #(.DATA_W(8), .DEPTH(DB), .FWFT(1'b1)) u_dut_b (
        .clk(clk), .rst(rst),
        .push_en(push_en_b), .push_data(push_data_b),
        .pop_en(pop_en_b), .pop_data(pop_data_b), .pop_valid(pop_valid_b),
        .count(count_b), .full(full_b), .empty(empty_b),
        .almost_full(almost_full_b), .almost_empty(almost_empty_b),
        .overflow(overflow_b), .underflow(underflow_b), .clr_err(clr_err_b)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: contents as plain queues plus sticky flags.
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic       ova = 1'b0, una = 1'b0, ovb = 1'b0, unb = 1'b0;
    // Scoreboards of data expected at the output, in order.
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    logic [7:0] last_a = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, req, $time);
        end
    endtask

    task automatic check_a();
        int n;
        n = qa.size();
        chk("count_a", 32'(count_a), 32'(n));
        chk("flags_a", {26'd0, full_a, empty_a, almost_full_a, almost_empty_a, overflow_a, underflow_a},
            {26'd0, n == DA, n == 0, n >= 6, n <= 2, ova, una});
    endtask

    task automatic check_b();
        int n;
        n = qb.size();
        chk("count_b", 32'(count_b), 32'(n));
        chk("flags_b", {26'd0, full_b, empty_b, almost_full_b, almost_empty_b, overflow_b, underflow_b},
            {26'd0, n == DB, n == 0, n >= DB - 2, n <= 2, ovb, unb});
        chk("pop_valid_b", 32'(pop_valid_b), 32'(n != 0));
        if (n != 0) chk("head_b", 32'(pop_data_b), 32'(qb[0]));
    endtask

    // Synchronous reset for both instances; entered and left at posedge+1.
    task automatic do_reset();
        rst = 1'b1;
        push_en_a = 0; pop_en_a = 0; clr_err_a = 0;
        push_en_b = 0; pop_en_b = 0; clr_err_b = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        qa.delete(); qb.delete(); exp_a.delete(); exp_b.delete();
        ova = 0; una = 0; ovb = 0; unb = 0; last_a = '0;
        check_a();
        check_b();
    endtask

    // One clock of stimulus on A; model is committed after the edge.
    task automatic cyc_a(input bit pe, input logic [7:0] pd, input bit po, input bit ce);
        bit         full_m, empty_m, acc_push, acc_pop;
        logic [7:0] head;
        head = '0;
        push_en_a = pe; push_data_a = pd; pop_en_a = po; clr_err_a = ce;
        full_m   = (qa.size() == DA);
        empty_m  = (qa.size() == 0);
        acc_push = pe && !full_m;
        acc_pop  = po && !empty_m;
        if (acc_pop) head = qa[0];
        @(posedge clk); #1;
        if (acc_pop) begin qa.delete(0); exp_a.push_back(head); end
        if (acc_push) qa.push_back(pd);
        ova = (pe && full_m) ? 1'b1 : (ce ? 1'b0 : ova);
        una = (po && empty_m) ? 1'b1 : (ce ? 1'b0 : una);
        check_a();
    endtask

    // One clock of stimulus on B; the consumed head is expected before the edge.
    task automatic cyc_b(input bit pe, input logic [7:0] pd, input bit po, input bit ce);
        bit full_m, empty_m, acc_push, acc_pop;
        push_en_b = pe; push_data_b = pd; pop_en_b = po; clr_err_b = ce;
        full_m   = (qb.size() == DB);
        empty_m  = (qb.size() == 0);
        acc_push = pe && !full_m;
        acc_pop  = po && !empty_m;
        if (acc_pop) exp_b.push_back(qb[0]);
        @(posedge clk); #1;
        if (acc_pop) qb.delete(0);
        if (acc_push) qb.push_back(pd);
        ovb = (pe && full_m) ? 1'b1 : (ce ? 1'b0 : ovb);
        unb = (po && empty_m) ? 1'b1 : (ce ? 1'b0 : unb);
        check_b();
    endtask

    // Monitor A: every valid output must be the next scoreboard entry;
    // otherwise pop_data must hold its last value.
    always @(negedge clk) begin
        if (!rst) begin
            if (pop_valid_a) begin
                if (exp_a.size() == 0) begin
                    chk("pop_a_spurious", 32'(pop_valid_a), 32'd0);
                end else begin
                    chk("pop_data_a", 32'(pop_data_a), 32'(exp_a[0]));
                    last_a = exp_a[0];
                    exp_a.delete(0);
                end
            end else begin
                chk("hold_a", 32'(pop_data_a), 32'(last_a));
            end
        end
    end

    // Monitor B: a consumed head must be the next scoreboard entry.
    always @(negedge clk) begin
        if (!rst && pop_en_b && pop_valid_b) begin
            if (exp_b.size() == 0) begin
                chk("pop_b_spurious", 32'(pop_valid_b), 32'd0);
            end else begin
                chk("pop_data_b", 32'(pop_data_b), 32'(exp_b[0]));
                exp_b.delete(0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // T1: fill with A0..A7, then drain in order
        for (int i = 0; i < 8; i++) cyc_a(1, 8'(8'hA0 + i), 0, 0);
        chk("t1_full", 32'(full_a), 32'd1);
        for (int i = 0; i < 8; i++) cyc_a(0, 8'h00, 1, 0);
        cyc_a(0, 8'h00, 0, 0);
        chk("t1_empty", 32'(empty_a), 32'd1);

        // T3: full with push+pop -> pop wins, push dropped, overflow set
        do_reset();
        for (int i = 0; i < 8; i++) cyc_a(1, 8'($urandom_range(0, 254)), 0, 0);
        cyc_a(1, 8'hFF, 1, 0);
        chk("t3_count", 32'(count_a), 32'd7);
        chk("t3_ovf", 32'(overflow_a), 32'd1);
        cyc_a(0, 8'h00, 0, 1);
        chk("t3_clr", 32'(overflow_a), 32'd0);
        cyc_a(1, 8'hEE, 0, 0);
        cyc_a(1, 8'hDD, 0, 1);          // violation and clear together: set wins
        chk("t3_setwins", 32'(overflow_a), 32'd1);
        cyc_a(0, 8'h00, 0, 1);
        for (int i = 0; i < 9; i++) cyc_a(0, 8'h00, 1, 0);
        cyc_a(0, 8'h00, 0, 0);

        // T4: empty with push+pop -> push accepted, underflow set
        do_reset();
        cyc_a(1, 8'h55, 1, 0);
        chk("t4_count", 32'(count_a), 32'd1);
        chk("t4_unf", 32'(underflow_a), 32'd1);
        cyc_a(0, 8'h00, 1, 0);
        cyc_a(0, 8'h00, 0, 0);

        // Random traffic on A with a mid-run reset (T5 thresholds checked every cycle)
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            cyc_a(($urandom_range(0, 99) < ((i % 100) < 50 ? 70 : 35)),
                  8'($urandom), ($urandom_range(0, 99) < 50), ($urandom_range(0, 15) == 0));
        end
        cyc_a(0, 8'h00, 0, 1);
        while (qa.size() != 0) cyc_a(0, 8'h00, 1, 0);
        cyc_a(0, 8'h00, 0, 0);
        chk("exp_a_drained", 32'(exp_a.size()), 32'd0);

        // T2: DEPTH 6, interleaved traffic across pointer wrap
        do_reset();
        for (int i = 0; i < 20; i++) cyc_b((i % 3) != 2, 8'(8'h30 + i), (i % 2) == 1, 0);
        chk("t2_no_err", {30'd0, overflow_b, underflow_b}, 32'd0);
        while (qb.size() != 0) cyc_b(0, 8'h00, 1, 0);

        // Random traffic on B
        for (int i = 0; i < 400; i++)
            cyc_b(($urandom_range(0, 99) < ((i % 80) < 40 ? 70 : 35)),
                  8'($urandom), ($urandom_range(0, 99) < 50), ($urandom_range(0, 15) == 0));
        while (qb.size() != 0) cyc_b(0, 8'h00, 1, 0);

        // T6: FWFT shows head without a pop; reset with 4 entries empties it
        do_reset();
        cyc_b(1, 8'h11, 0, 0);
        chk("t6_valid", 32'(pop_valid_b), 32'd1);
        chk("t6_data", 32'(pop_data_b), 32'h11);
        for (int i = 0; i < 3; i++) cyc_b(1, 8'(8'h12 + i), 0, 0);
        chk("t6_count4", 32'(count_b), 32'd4);
        do_reset();
        chk("t6_empty", 32'(empty_b), 32'd1);
        chk("t6_novalid", 32'(pop_valid_b), 32'd0);
        cyc_b(0, 8'h00, 0, 0);
        chk("exp_b_drained", 32'(exp_b.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
